// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-port data memory
// between a data-cache requester (D) and an instruction-fetch requester (I).
// One transaction at a time: IDLE -> ISSUE -> (WAIT x RD_LAT) -> RESP -> IDLE.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    // data-cache requester
    input  logic          d_req,
    input  logic [7:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    // instruction-fetch requester
    input  logic          i_req,
    input  logic [7:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    // single-port memory
    output logic          rden,
    output logic [7:0]    wren,
    output logic [AW-1:0] rdaddress,
    output logic [AW-1:0] wraddress,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data,
    // status
    output logic          busy,
    output logic          gnt_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // WAIT cycles remaining after the first one; loaded in ISSUE.
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;        // owner of the current transaction, 1 = I
    logic          last_q, last_d;      // most recent winner; a tie goes to the other port
    logic [7:0]    we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic          pick_i;              // winner chosen in IDLE, 1 = I

    // Next-state, latch and memory-strobe decode for the transaction FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;
        pick_i    = 1'b0;
        rden      = 1'b0;
        wren      = 8'h00;
        d_ack     = 1'b0;
        i_ack     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    // On a tie the port that did not win last time goes first.
                    pick_i  = (d_req && i_req) ? ~last_q : i_req;
                    gnt_d   = pick_i;
                    we_d    = pick_i ? i_we    : d_we;
                    addr_d  = pick_i ? i_addr  : d_addr;
                    wdata_d = pick_i ? i_wdata : d_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q != 8'h00) begin
                    wren    = we_q;
                    state_d = RESP;
                end else begin
                    rden    = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    // read_data is valid in the last WAIT cycle; only the owner's register moves.
                    if (gnt_q) i_rdata_d = read_data;
                    else       d_rdata_d = read_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                d_ack   = ~gnt_q;
                i_ack   = gnt_q;
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            // "I won last" makes D the winner of the first tie after reset.
            last_q    <= 1'b1;
            we_q      <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 3'd0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            d_rdata_q <= d_rdata_d;
            i_rdata_q <= i_rdata_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign gnt_id     = gnt_q;
    assign rdaddress  = addr_q;
    assign wraddress  = addr_q;
    assign write_data = wdata_q;
    assign d_rdata    = d_rdata_q;
    assign i_rdata    = i_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3, each attached to a small behavioural memory.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    // ---------------- instance with RD_LAT = 1 ----------------
    logic        d_req, i_req;
    logic [7:0]  d_we, i_we;
    logic [31:0] d_addr, i_addr;
    logic [63:0] d_wdata, i_wdata;
    logic        d_ack, i_ack;
    logic [63:0] d_rdata, i_rdata;
    logic        rden;
    logic [7:0]  wren;
    logic [31:0] rdaddress, wraddress;
    logic [63:0] write_data;
    logic [63:0] read_data = '0;
    logic        busy, gnt_id;

    // ---------------- instance with RD_LAT = 3 ----------------
    logic        d3_req, i3_req;
    logic [7:0]  d3_we, i3_we;
    logic [31:0] d3_addr, i3_addr;
    logic [63:0] d3_wdata, i3_wdata;
    logic        d3_ack, i3_ack;
    logic [63:0] d3_rdata, i3_rdata;
    logic        rden3;
    logic [7:0]  wren3;
    logic [31:0] rdaddr3, wraddr3;
    logic [63:0] wdata3;
    logic [63:0] rdata3 = '0;
    logic [63:0] p3_0 = '0, p3_1 = '0;
    logic        busy3, gnt3;

    logic [63:0] mem1 [0:127];
    logic [63:0] mem3 [0:127];

    int rd_cnt1 = 0, wr_cnt1 = 0, d_ack_cnt = 0, i_ack_cnt = 0;
    int tests = 0, fails = 0;
    int base_rd, base_wr, base_dack, base_iack;

    mem_arbiter #(.AW(32), .DW(64), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ack(i_ack), .i_rdata(i_rdata),
        .rden(rden), .wren(wren), .rdaddress(rdaddress), .wraddress(wraddress),
        .write_data(write_data), .read_data(read_data),
        .busy(busy), .gnt_id(gnt_id)
    );

    mem_arbiter #(.AW(32), .DW(64), .RD_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_ack(d3_ack), .d_rdata(d3_rdata),
        .i_req(i3_req), .i_we(i3_we), .i_addr(i3_addr), .i_wdata(i3_wdata),
        .i_ack(i3_ack), .i_rdata(i3_rdata),
        .rden(rden3), .wren(wren3), .rdaddress(rdaddr3), .wraddress(wraddr3),
        .write_data(wdata3), .read_data(rdata3),
        .busy(busy3), .gnt_id(gnt3)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    // Memory behind u1: byte-masked writes, one-cycle read latency, access counters.
    always @(posedge clk) begin
        if (wren != 8'h00) begin
            mem1[wraddress[9:3]] = (mem1[wraddress[9:3]] & ~be_mask(wren)) |
                                   (write_data & be_mask(wren));
            wr_cnt1 <= wr_cnt1 + 1;
        end
        if (rden) rd_cnt1 <= rd_cnt1 + 1;
        read_data <= rden ? mem1[rdaddress[9:3]] : 64'h0;
        if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
        if (i_ack) i_ack_cnt <= i_ack_cnt + 1;
    end

    // Memory behind u3: three-stage read pipeline.
    always @(posedge clk) begin
        if (wren3 != 8'h00)
            mem3[wraddr3[9:3]] = (mem3[wraddr3[9:3]] & ~be_mask(wren3)) |
                                 (wdata3 & be_mask(wren3));
        p3_0   <= rden3 ? mem3[rdaddr3[9:3]] : 64'h0;
        p3_1   <= p3_0;
        rdata3 <= p3_1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int w = 0; w < 128; w++) begin
            mem1[w] = 64'h0;
            mem3[w] = 64'h0;
        end
        mem3[8] = 64'hCAFE_F00D_0123_4567;   // word at 0x40
        rst = 1'b1;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_req = 0; i_we = 0; i_addr = 0; i_wdata = 0;
        d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
        i3_req = 0; i3_we = 0; i3_addr = 0; i3_wdata = 0;
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rden",   64'(rden),      64'd0);
        check("rst_wren",   64'(wren),      64'd0);
        check("rst_d_ack",  64'(d_ack),     64'd0);
        check("rst_i_ack",  64'(i_ack),     64'd0);
        check("rst_busy",   64'(busy),      64'd0);
        check("rst_gnt",    64'(gnt_id),    64'd0);
        check("rst_d_rdata", d_rdata,       64'd0);
        check("rst_i_rdata", i_rdata,       64'd0);
        check("rst_addr",   64'(wraddress), 64'd0);
        check("rst_wdata",  write_data,     64'd0);
        rst = 1'b1;
        tick();

        // Single D write
        d_req = 1; d_we = 8'hFF; d_addr = 32'h40; d_wdata = 64'hDEAD_BEEF;
        base_wr = wr_cnt1;
        tick();
        check("wr_issue_wren",  64'(wren),      64'hFF);
        check("wr_issue_rden",  64'(rden),      64'd0);
        check("wr_issue_waddr", 64'(wraddress), 64'h40);
        check("wr_issue_wdata", write_data,     64'hDEAD_BEEF);
        check("wr_issue_busy",  64'(busy),      64'd1);
        check("wr_issue_ack",   64'(d_ack),     64'd0);
        tick();
        check("wr_resp_ack",   64'(d_ack), 64'd1);
        check("wr_resp_iack",  64'(i_ack), 64'd0);
        check("wr_resp_wren",  64'(wren),  64'd0);
        d_req = 0;
        tick();
        check("wr_idle_ack",   64'(d_ack),           64'd0);
        check("wr_idle_busy",  64'(busy),            64'd0);
        check("wr_count",      64'(wr_cnt1 - base_wr), 64'd1);

        // D read back, RD_LAT=1
        d_req = 1; d_we = 8'h00; d_addr = 32'h40;
        base_rd = rd_cnt1;
        tick();
        check("rd_issue_rden",  64'(rden),      64'd1);
        check("rd_issue_wren",  64'(wren),      64'd0);
        check("rd_issue_raddr", 64'(rdaddress), 64'h40);
        tick();
        check("rd_wait_rden",   64'(rden),  64'd0);
        check("rd_wait_busy",   64'(busy),  64'd1);
        check("rd_wait_ack",    64'(d_ack), 64'd0);
        tick();
        check("rd_resp_ack",    64'(d_ack), 64'd1);
        check("rd_resp_data",   d_rdata,    64'hDEAD_BEEF);
        d_req = 0;
        tick();
        check("rd_count",       64'(rd_cnt1 - base_rd), 64'd1);

        // Lone I read: exercises the I side and leaves I as last winner
        i_req = 1; i_we = 8'h00; i_addr = 32'h40;
        tick();
        check("ird_gnt",  64'(gnt_id), 64'd1);
        check("ird_rden", 64'(rden),   64'd1);
        tick();
        tick();
        check("ird_iack", 64'(i_ack), 64'd1);
        check("ird_dack", 64'(d_ack), 64'd0);
        check("ird_data", i_rdata,    64'hDEAD_BEEF);
        i_req = 0;
        tick();

        // Both requesting together and held: grants alternate D, I, D, I
        d_req = 1; d_we = 8'h0F; d_addr = 32'h80; d_wdata = 64'h1111_1111_1111_1111;
        i_req = 1; i_we = 8'hFF; i_addr = 32'h88; i_wdata = 64'h2222_2222_2222_2222;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt",  64'(gnt_id), 64'(k[0]));
            check("rr_wren", 64'(wren),   k[0] ? 64'hFF : 64'h0F);
            tick();
            check("rr_dack", 64'(d_ack), 64'(!k[0]));
            check("rr_iack", 64'(i_ack), 64'(k[0]));
            if (k == 3) begin
                d_req = 0;
                i_req = 0;
            end
            tick();
            check("rr_idle_busy", 64'(busy), 64'd0);
        end

        // I write whose req drops right after being latched
        i_req = 1; i_we = 8'hFF; i_addr = 32'h90; i_wdata = 64'h3333_3333_3333_3333;
        base_wr = wr_cnt1; base_iack = i_ack_cnt;
        tick();
        check("drop_gnt",  64'(gnt_id), 64'd1);
        check("drop_wren", 64'(wren),   64'hFF);
        i_req = 0;
        tick();
        check("drop_iack", 64'(i_ack), 64'd1);
        tick();
        tick();
        check("drop_busy",  64'(busy),                  64'd0);
        check("drop_wrcnt", 64'(wr_cnt1 - base_wr),     64'd1);
        check("drop_ackcnt", 64'(i_ack_cnt - base_iack), 64'd1);

        // D read of 0x80: only the low four bytes were written; I's rdata is untouched
        d_req = 1; d_we = 8'h00; d_addr = 32'h80;
        tick();
        tick();
        tick();
        check("be_ack",   64'(d_ack), 64'd1);
        check("be_data",  d_rdata,    64'h0000_0000_1111_1111);
        check("be_ihold", i_rdata,    64'hDEAD_BEEF);
        d_req = 0;
        tick();

        // Reset asserted during WAIT
        d_req = 1; d_we = 8'h00; d_addr = 32'h40;
        base_dack = d_ack_cnt;
        tick();
        tick();
        check("mid_wait_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rden",  64'(rden),   64'd0);
        check("mid_rst_wren",  64'(wren),   64'd0);
        check("mid_rst_dack",  64'(d_ack),  64'd0);
        check("mid_rst_iack",  64'(i_ack),  64'd0);
        check("mid_rst_busy",  64'(busy),   64'd0);
        check("mid_rst_gnt",   64'(gnt_id), 64'd0);
        check("mid_rst_rdata", d_rdata,     64'd0);
        d_req = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) tick();
        check("post_rst_noack", 64'(d_ack_cnt - base_dack), 64'd0);
        check("post_rst_busy",  64'(busy),                  64'd0);

        // First tie after reset goes to D even though D won last before reset
        d_req = 1; d_we = 8'hFF; d_addr = 32'hA0; d_wdata = 64'h4444;
        i_req = 1; i_we = 8'hFF; i_addr = 32'hA8; i_wdata = 64'h5555;
        tick();
        check("tie_after_rst_gnt", 64'(gnt_id), 64'd0);
        tick();
        check("tie_after_rst_ack", 64'(d_ack), 64'd1);
        d_req = 0;
        i_req = 0;
        tick();

        // RD_LAT=3 read on the second instance
        d3_req = 1; d3_we = 8'h00; d3_addr = 32'h40;
        tick();
        check("lat3_rden", 64'(rden3), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("lat3_wait_busy", 64'(busy3),  64'd1);
            check("lat3_wait_ack",  64'(d3_ack), 64'd0);
            check("lat3_wait_rden", 64'(rden3),  64'd0);
        end
        tick();
        check("lat3_ack",  64'(d3_ack), 64'd1);
        check("lat3_data", d3_rdata,    64'hCAFE_F00D_0123_4567);
        d3_req = 0;
        tick();
        check("lat3_idle", 64'(busy3), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the memory address width in bits.
REQ-002 The block SHALL have parameter DW, default 64, meaning the data width in bits.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning cycles from rden assertion to valid read_data, legal range 1..7.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have ports d_req/d_we/d_addr/d_wdata, input, 1/8/AW/DW bits: the data-cache requester's request, byte write enables (all-zero means read), address and write data.
REQ-007 The block SHALL have ports d_ack/d_rdata, output, 1/DW bits: the data-cache requester's completion pulse and read data.
REQ-008 The block SHALL have ports i_req/i_we/i_addr/i_wdata and i_ack/i_rdata with the same directions, widths and meanings for the instruction-fetch requester.
REQ-009 The block SHALL have ports rden (output, 1), wren (output, 8), rdaddress/wraddress (output, AW), write_data (output, DW) and read_data (input, DW): the single-port data memory interface.
REQ-010 The block SHALL have ports busy (output, 1): transaction in flight; and gnt_id (output, 1): current owner, 0=D, 1=I.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-012 In IDLE with any request high, the block SHALL select a winner, latch its we/addr/wdata into internal registers and go to ISSUE next cycle.
REQ-013 With both requests high in the same IDLE cycle, the winner SHALL be the port not granted most recently (round robin); the pointer resets so D wins the first tie.
REQ-014 ISSUE SHALL last exactly one cycle: for a write, wren = latched we and rden = 0; for a read, rden = 1 and wren = 0.
REQ-015 rdaddress and wraddress SHALL both equal the latched address, and write_data the latched wdata, in every state.
REQ-016 rden and wren SHALL be 0 in every state other than ISSUE.
REQ-017 After a write ISSUE the FSM SHALL go to RESP; after a read ISSUE it SHALL go to WAIT.
REQ-018 A 3-bit counter SHALL hold the FSM in WAIT for RD_LAT cycles, and read_data SHALL be captured into the winner's rdata register on the last WAIT cycle.
REQ-019 RESP SHALL last one cycle: pulse the winner's ack high, update the round-robin pointer to the winner, and return to IDLE.
REQ-020 The loser's ack SHALL stay 0, and its rdata register SHALL hold its last value.
REQ-021 Latency from the request-sampling IDLE edge to the ack cycle SHALL be 2 cycles for writes and RD_LAT+2 cycles for reads.
REQ-022 No request is accepted outside IDLE; back-to-back transactions therefore have a minimum spacing of one IDLE cycle.
REQ-023 A requester SHALL hold req and its payload until ack; a req dropped before being latched is ignored with no ack.
REQ-024 A req dropped after latching SHALL NOT abort the transaction, and ack is still issued.
REQ-025 A requester still asserting req in the ack cycle SHALL be treated as a new request at the next IDLE.
REQ-026 A waiting requester SHALL be granted no later than the transaction following the current one (no starvation).
REQ-027 busy SHALL be 1 in ISSUE, WAIT and RESP, and 0 in IDLE.
REQ-028 gnt_id SHALL hold the latched winner from ISSUE through RESP.

Reset
REQ-029 While rst = 0, the block SHALL immediately force state = IDLE, rden = 0, wren = 8'h00, d_ack = i_ack = 0, busy = 0, gnt_id = 0, d_rdata = i_rdata = 0, latched address/data = 0, counter = 0 and pointer = favour D.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction without an ack; the requester must re-request after reset release.

Verification
REQ-031 Single D write (d_req=1, d_we=8'hFF, d_addr=32'h40, d_wdata=64'hDEAD_BEEF) -> wren=8'hFF for exactly 1 cycle with wraddress=32'h40, and d_ack pulses 2 cycles after sampling.
REQ-032 D read of 32'h40 after REQ-031, with RD_LAT=1 -> rden pulses once, and d_rdata=64'hDEAD_BEEF when d_ack pulses 3 cycles after sampling.
REQ-033 d_req and i_req rising together and held continuously -> grants alternate D, I, D, I, with each ack to its own port only.
REQ-034 i_req dropped in the cycle after latching -> i_ack still pulses and memory access occurs once.
REQ-035 rst driven low during WAIT -> rden/wren/acks 0 asynchronously, busy=0, and no ack after release until a new request.
REQ-036 RD_LAT=3 read -> WAIT lasts 3 cycles and ack occurs 5 cycles after sampling.
